ip_mask_encoder: RTL

Sequential inner-product masking (IPM) encoder. It takes an unmasked secret byte, v−1 fresh random bytes and the public vector L. It produces the v-byte masked share vector Z such that the GF(2^8) sum of L_i·Z_i equals the secret. It sits directly upstream of the IPM share-vector adder and feeds its R/Q operands. It uses one GF(2^8) multiplier, time-shared over v−1 cycles.

---
 rtl/ipm_pkg.sv | 19 +
 rtl/ip_mask_encoder_if.sv | 27 ++
 rtl/gf256_mul.sv | 25 ++
 rtl/ip_mask_encoder.sv | 103 ++++++++++
 4 files changed

// File: rtl/ipm_pkg.sv
// Shared definitions for the inner-product masking encoder: byte width,
// GF(2^8) reduction constant, FSM state encoding and a byte-lane helper.
package ipm_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // LSB position of byte lane i in a packed byte vector
  function automatic int unsigned byte_lsb(input int unsigned i);
    return i * BYTE_W;
  endfunction

endpackage

// File: rtl/ip_mask_encoder_if.sv
// Request/response bundle of the masking encoder; master is the upstream
// producer and downstream consumer side, slave is the encoder itself.
interface ip_mask_encoder_if #(
  parameter int v = 8
);
  import ipm_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [BYTE_W-1:0]          x;
  logic [(v-1)*BYTE_W-1:0]    rnd;
  logic [v*BYTE_W-1:0]        l;
  logic                       out_valid;
  logic                       out_ready;
  logic [v*BYTE_W-1:0]        z;

  modport master (
    output in_valid, x, rnd, l, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, x, rnd, l, out_ready,
    output in_ready, out_valid, z
  );

endinterface

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier over x^8+x^4+x^3+x+1, built as
// shift-and-add with conditional reduction after every doubling.
module gf256_mul
  import ipm_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  output logic [BYTE_W-1:0] o_p
);

  logic [BYTE_W-1:0] w_a;
  logic [BYTE_W-1:0] w_prod;

  always_comb begin
    w_a    = i_a;
    w_prod = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      if (i_b[i]) w_prod = w_prod ^ w_a;
      w_a = {w_a[BYTE_W-2:0], 1'b0} ^ (w_a[BYTE_W-1] ? GF_POLY : '0);
    end
  end

  assign o_p = w_prod;

endmodule

// File: rtl/ip_mask_encoder.sv
// Sequential IPM encoder: z[0] = x ^ sum(L_i*R_i), z[i] = R_i, one shared
// GF(2^8) multiplier stepped through the v-1 lanes.
//
//   state | meaning
//   IDLE  | ready for a request, inputs sampled on in_valid
//   ACC   | one L_idx*R_idx product folded into acc per cycle
//   DONE  | z presented, held until out_ready
module ip_mask_encoder
  import ipm_pkg::*;
#(
  parameter int v = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ip_mask_encoder_if.slave  bus
);

  localparam int IDX_W = $clog2(v);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(v - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [IDX_W-1:0]           r_idx;
  logic [BYTE_W-1:0]          r_acc;
  logic [(v-1)*BYTE_W-1:0]    r_rnd;
  logic [(v-1)*BYTE_W-1:0]    r_l;
  logic                       r_live;

  logic [BYTE_W-1:0]          w_l_op [v];
  logic [BYTE_W-1:0]          w_r_op [v];
  logic [BYTE_W-1:0]          w_prod;
  logic                       w_last;
  logic                       w_accept;
  logic                       w_in_ready;
  logic                       w_out_valid;
  logic                       w_unused_l0;

  // Lane 0 is never multiplied; its fixed L=1 is implicit in acc starting at x
  assign w_l_op[0] = 8'h01;
  assign w_r_op[0] = '0;
  for (genvar i = 1; i < v; i++) begin : g_lane
    assign w_l_op[i] = r_l[byte_lsb(i-1) +: BYTE_W];
    assign w_r_op[i] = r_rnd[byte_lsb(i-1) +: BYTE_W];
  end

  assign w_unused_l0 = ^bus.l[BYTE_W-1:0];

  gf256_mul u_mul (
    .i_a (w_l_op[r_idx]),
    .i_b (w_r_op[r_idx]),
    .o_p (w_prod)
  );

  assign w_last   = (r_idx == IDX_LAST);
  assign w_accept = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)      w_state_nxt = ACC;
      ACC:     if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // r_live keeps in_ready low until the first edge after reset release
  always_comb begin
    w_in_ready  = (r_state == IDLE) & r_live;
    w_out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
      r_idx  <= '0;
      r_acc  <= '0;
      r_rnd  <= '0;
      r_l    <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_acc <= bus.x;
        r_rnd <= bus.rnd;
        r_l   <= bus.l[v*BYTE_W-1:BYTE_W];
        r_idx <= IDX_W'(1);
      end else if (r_state == ACC) begin
        r_acc <= r_acc ^ w_prod;
        if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.z         = w_out_valid ? {r_rnd, r_acc} : '0;

endmodule
